// File: rtl/io_handshake_unit.sv
// Handshaked input sequencer and addressable output register bank for the ARMAria core.
// Optional input timeout is compiled in with the IO_TIMEOUT_EN macro.
module io_handshake_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int SW_WIDTH       = 16,
  parameter int OUT_CHANNELS   = 4,
  parameter int CH_SEL_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               is_input,
  input  logic                               is_output,
  input  logic [CH_SEL_WIDTH-1:0]            channel_sel,
  input  logic [DATA_WIDTH-1:0]              out_data,
  input  logic [SW_WIDTH-1:0]                sw,
  input  logic                               sw_signed,
  input  logic                               confirm,
  output logic                               stall,
  output logic [DATA_WIDTH-1:0]              in_data,
  output logic                               in_valid,
  output logic [OUT_CHANNELS*DATA_WIDTH-1:0] out_regs,
  output logic [OUT_CHANNELS-1:0]            out_strobe,
  output logic                               timed_out
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic                    confirm_q_reg;
  logic [DATA_WIDTH-1:0]   in_data_reg;
  logic                    in_valid_reg;
  logic [DATA_WIDTH-1:0]   sw_ext;
  logic                    rise;
  logic                    fall;
  logic                    timeout_hit;
  logic                    press_entry;
  logic                    write_en;

  assign rise        = confirm & ~confirm_q_reg;
  assign fall        = ~confirm & confirm_q_reg;
  assign press_entry = (state_reg == IDLE) && is_input;

  // Stall is combinational so the core freezes in the very cycle it requests input.
  assign stall = press_entry || (state_reg == WAIT_PRESS) || (state_reg == WAIT_RELEASE);

  generate
    if (SW_WIDTH == DATA_WIDTH) begin : g_ext_copy
      assign sw_ext = sw;
    end else begin : g_ext_fill
      assign sw_ext = {{(DATA_WIDTH-SW_WIDTH){sw_signed & sw[SW_WIDTH-1]}}, sw};
    end
  endgenerate

`ifdef IO_TIMEOUT_EN
  logic [31:0] wait_cnt_reg;
  logic        timed_out_reg;

  // A genuine press in the final cycle takes priority over the timeout.
  assign timeout_hit = (state_reg == WAIT_PRESS) && !rise &&
                       (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_reg  <= '0;
      timed_out_reg <= 1'b0;
    end else if (press_entry) begin
      wait_cnt_reg  <= '0;
      timed_out_reg <= 1'b0;
    end else if (state_reg == WAIT_PRESS) begin
      wait_cnt_reg <= wait_cnt_reg + 32'd1;
      if (timeout_hit) begin
        timed_out_reg <= 1'b1;
      end
    end
  end

  assign timed_out = timed_out_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (is_input) begin
          state_next = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (rise) begin
          state_next = WAIT_RELEASE;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      WAIT_RELEASE: begin
        if (fall) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      confirm_q_reg <= 1'b0;
      in_data_reg   <= '0;
      in_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      confirm_q_reg <= confirm;
      in_valid_reg  <= (state_next == DONE);
      if ((state_reg == WAIT_PRESS) && rise) begin
        in_data_reg <= sw_ext;
      end else if (timeout_hit) begin
        in_data_reg <= '0;
      end
    end
  end

  assign in_data  = in_data_reg;
  assign in_valid = in_valid_reg;

  // Out-of-range selects match no channel, so they neither write nor strobe.
  assign write_en = is_output && !stall;

  generate
    for (genvar gi = 0; gi < OUT_CHANNELS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  strobe_reg;
      logic                  hit;

      assign hit = write_en && (channel_sel == CH_SEL_WIDTH'(gi));

      always_ff @(posedge clock) begin
        if (!reset) begin
          data_reg   <= '0;
          strobe_reg <= 1'b0;
        end else begin
          strobe_reg <= hit;
          if (hit) begin
            data_reg <= out_data;
          end
        end
      end

      assign out_regs[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
      assign out_strobe[gi]                        = strobe_reg;
    end
  endgenerate

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed self-checking bench for io_handshake_unit; one task per scenario.
// Build with IO_TIMEOUT_EN defined to also exercise the input timeout.
module tb_io_handshake_unit;

  localparam int DW  = 32;
  localparam int SWW = 16;
  localparam int NCH = 4;
  localparam int CSW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            is_input;
  logic            is_output;
  logic [CSW-1:0]  channel_sel;
  logic [DW-1:0]   out_data;
  logic [SWW-1:0]  sw;
  logic            sw_signed;
  logic            confirm;
  logic            stall;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic [NCH*DW-1:0] out_regs;
  logic [NCH-1:0]  out_strobe;
  logic            timed_out;

  int checks = 0;
  int errors = 0;
  logic [NCH*DW-1:0] exp_regs;

  io_handshake_unit #(
    .DATA_WIDTH    (DW),
    .SW_WIDTH      (SWW),
    .OUT_CHANNELS  (NCH),
    .CH_SEL_WIDTH  (CSW),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .is_input   (is_input),
    .is_output  (is_output),
    .channel_sel(channel_sel),
    .out_data   (out_data),
    .sw         (sw),
    .sw_signed  (sw_signed),
    .confirm    (confirm),
    .stall      (stall),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_regs   (out_regs),
    .out_strobe (out_strobe),
    .timed_out  (timed_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; is_input = 1'b0; is_output = 1'b0; channel_sel = '0;
    out_data = '0; sw = '0; sw_signed = 1'b0; confirm = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    exp_regs = '0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b exp 0", in_valid); end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data got %h exp 0", in_data); end
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL reset_out_regs got %h exp 0", out_regs); end
    checks++; if (out_strobe !== 4'b0) begin errors++; $display("FAIL reset_out_strobe got %b exp 0", out_strobe); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %b exp 0", timed_out); end
    $display("reset: stall=%b in_valid=%b in_data=%h", stall, in_valid, in_data);
  endtask

  task automatic test_signed_input();
    int pulses = 0;
    sw = 16'h8001; sw_signed = 1'b1; is_input = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sig_stall_request got %b exp 1", stall); end
    tick();                       // WAIT_PRESS
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sig_stall_hold%0d got %b exp 1", i, stall); end
      if (in_valid === 1'b1) pulses++;
      tick();
    end
    confirm = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sig_stall_release got %b exp 1", stall); end
    tick();                       // DONE
    checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL sig_in_valid got %b exp 1", in_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sig_stall_done got %b exp 0", stall); end
    checks++; if (in_data !== 32'hFFFF8001) begin errors++; $display("FAIL sig_in_data got %h exp FFFF8001", in_data); end
    if (in_valid === 1'b1) pulses++;
    is_input = 1'b0;
    tick();
    if (in_valid === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL sig_pulse_count got %0d exp 1", pulses); end
    $display("signed input: in_data=%h pulses=%0d", in_data, pulses);
  endtask

  task automatic test_preheld_zero_ext();
    confirm = 1'b1;
    tick();
    sw_signed = 1'b0; is_input = 1'b1;
    tick();                       // WAIT_PRESS, button already down
    tick();
    confirm = 1'b0;
    tick();                       // release: no latch
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_stall_after_release got %b exp 1", stall); end
    checks++; if (in_data !== 32'hFFFF8001) begin errors++; $display("FAIL pre_no_latch got %h exp FFFF8001", in_data); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pre_no_valid got %b exp 0", in_valid); end
    confirm = 1'b1;
    tick();                       // real press latches
    checks++; if (in_data !== 32'h00008001) begin errors++; $display("FAIL pre_in_data got %h exp 00008001", in_data); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_stall_wait_release got %b exp 1", stall); end
    confirm = 1'b0;
    tick();
    checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL pre_in_valid got %b exp 1", in_valid); end
    is_input = 1'b0;
    tick();
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pre_valid_one_cycle got %b exp 0", in_valid); end
    $display("preheld zero-ext: in_data=%h", in_data);
  endtask

  task automatic test_output_channels();
    is_output = 1'b1; channel_sel = 3'd2; out_data = 32'hDEADBEEF;
    tick();
    exp_regs[2*DW +: DW] = 32'hDEADBEEF;
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL out_ch2_regs got %h exp %h", out_regs, exp_regs); end
    checks++; if (out_strobe !== 4'b0100) begin errors++; $display("FAIL out_ch2_strobe got %b exp 0100", out_strobe); end
    channel_sel = 3'd5; out_data = 32'h1;
    tick();
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL out_ch5_regs got %h exp %h", out_regs, exp_regs); end
    checks++; if (out_strobe !== 4'b0000) begin errors++; $display("FAIL out_ch5_strobe got %b exp 0000", out_strobe); end
    channel_sel = 3'd0; out_data = 32'h0BAD_F00D;
    tick();
    exp_regs[0 +: DW] = 32'h0BAD_F00D;
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL out_ch0_regs got %h exp %h", out_regs, exp_regs); end
    checks++; if (out_strobe !== 4'b0001) begin errors++; $display("FAIL out_ch0_strobe got %b exp 0001", out_strobe); end
    is_output = 1'b0;
    tick();
    checks++; if (out_strobe !== 4'b0000) begin errors++; $display("FAIL out_idle_strobe got %b exp 0000", out_strobe); end
    $display("output channels: out_regs=%h", out_regs);
  endtask

  task automatic test_simultaneous();
    is_input = 1'b1; is_output = 1'b1; channel_sel = 3'd1; out_data = 32'h12345678;
    sw = 16'h00FF; sw_signed = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sim_stall got %b exp 1", stall); end
    tick();
    checks++; if (out_regs !== exp_regs || out_strobe !== 4'b0) begin errors++; $display("FAIL sim_no_write_press got %h/%b exp %h/0000", out_regs, out_strobe, exp_regs); end
    confirm = 1'b1;
    tick();
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL sim_no_write_release got %h exp %h", out_regs, exp_regs); end
    confirm = 1'b0;
    tick();                       // DONE
    checks++; if (in_valid !== 1'b1 || in_data !== 32'h000000FF) begin errors++; $display("FAIL sim_in_valid got %b/%h exp 1/000000FF", in_valid, in_data); end
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL sim_no_write_done got %h exp %h", out_regs, exp_regs); end
    is_input = 1'b0;
    tick();                       // retried write lands
    exp_regs[1*DW +: DW] = 32'h12345678;
    checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL sim_write_after got %h exp %h", out_regs, exp_regs); end
    checks++; if (out_strobe !== 4'b0010) begin errors++; $display("FAIL sim_strobe_after got %b exp 0010", out_strobe); end
    is_output = 1'b0;
    tick();
    $display("simultaneous: out_regs=%h", out_regs);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    sw = 16'h1234; sw_signed = 1'b0; is_input = 1'b1;
    tick();
    confirm = 1'b1;
    tick();                       // WAIT_RELEASE
    checks++; if (in_data !== 32'h00001234) begin errors++; $display("FAIL mid_latched got %h exp 00001234", in_data); end
    reset = 1'b0;
    tick();
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL mid_in_data got %h exp 0", in_data); end
    checks++; if (out_regs !== '0) begin errors++; $display("FAIL mid_out_regs got %h exp 0", out_regs); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_follow1 got %b exp 1", stall); end
    exp_regs = '0;
    if (in_valid === 1'b1) pulses++;
    is_input = 1'b0; confirm = 1'b0; reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_follow0 got %b exp 0", stall); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (in_valid === 1'b1) pulses++;
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_idle_stall got %b exp 0", stall); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_valid got %0d exp 0", pulses); end
    $display("reset mid-handshake: in_data=%h pulses=%0d", in_data, pulses);
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    sw = 16'hABCD; is_input = 1'b1; confirm = 1'b0;
    for (int i = 0; i < 30 && in_valid !== 1'b1; i++) begin
      tick();
      n++;
    end
    checks++; if (in_valid !== 1'b1 || n != 11) begin errors++; $display("FAIL to_latency got %0d valid=%b exp 11", n, in_valid); end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL to_in_data got %h exp 0", in_data); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", timed_out); end
    is_input = 1'b0;
    tick();
    is_input = 1'b1;
    tick();                       // re-entry clears the flag
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timed_out); end
    confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    checks++; if (in_valid !== 1'b1 || in_data !== 32'h0000ABCD) begin errors++; $display("FAIL to_normal got %b/%h exp 1/0000ABCD", in_valid, in_data); end
    is_input = 1'b0;
    tick();
    $display("timeout: latency=%0d", n);
  endtask
`else
  task automatic test_timeout();
    is_input = 1'b1; confirm = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall !== 1'b1 || in_valid !== 1'b0) begin errors++; $display("FAIL no_to_wait got %b/%b exp 1/0", stall, in_valid); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL no_to_flag got %b exp 0", timed_out); end
    confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    is_input = 1'b0;
    tick();
    $display("no timeout: still waiting after 15 cycles");
  endtask
`endif

  initial begin
    test_reset();
    test_signed_input();
    test_preheld_zero_ext();
    test_output_channels();
    test_simultaneous();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
